// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: groups the client handshakes with the RAM address/strobe of the RAM bus master.
// Latency: none, this is a signal bundle only.
// Backpressure: valid/ready on req, wdata and rsp channels; mem_addr/mem_write are driven by the master.
// Ports: params address_width/data_width; modport master = sequencer, modport slave = client and RAM side.
interface mem_bus_master_if #(
  parameter int address_width = 4,
  parameter int data_width    = 6
);
  // request channel
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [address_width-1:0] req_addr;
  logic [address_width-1:0] req_len;
  // write-data channel
  logic                     wdata_valid;
  logic                     wdata_ready;
  logic [data_width-1:0]    wdata;
  // read-response channel
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [data_width-1:0]    rsp_rdata;
  logic                     rsp_last;
  logic                     wr_done;
  // RAM address and write strobe (the data bus is a separate inout)
  logic [address_width-1:0] mem_addr;
  logic                     mem_write;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata,
    input  rsp_ready,
    output req_ready, wdata_ready,
    output rsp_valid, rsp_rdata, rsp_last, wr_done,
    output mem_addr, mem_write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata,
    output rsp_ready,
    input  req_ready, wdata_ready,
    input  rsp_valid, rsp_rdata, rsp_last, wr_done,
    input  mem_addr, mem_write
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences client read/write bursts onto a single-port RAM with a shared data bus.
// Latency: read word registered one edge after RD; write commits at the end of the WR cycle, wr_done next cycle.
// Backpressure: req accepted only in IDLE; write beats wait on wdata_valid; read beats hold until rsp_ready.
// Ports: clk, reset_n (async active-low), bus (mem_bus_master_if.master), mem_data (inout RAM data bus).
module mem_bus_master #(
  parameter int address_width = 4,
  parameter int data_width    = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_bus_master_if.master      bus,
  inout  wire  [data_width-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [address_width-1:0] ADDR_ONE = address_width'(1);

  state_t                   state_q;
  logic [address_width-1:0] cur_addr_q;
  logic [address_width-1:0] remaining_q;
  logic [data_width-1:0]    wdat_q;
  logic [data_width-1:0]    rsp_rdata_q;
  logic                     req_ready_q;
  logic                     wdata_ready_q;
  logic                     mem_write_q;
  logic                     rsp_valid_q;
  logic                     rsp_last_q;
  logic                     wr_done_q;

  // The RAM only releases the bus while the strobe is high, so the strobe
  // register doubles as our output enable: no contention by construction.
  assign mem_data = mem_write_q ? wdat_q : {data_width{1'bz}};

  assign bus.req_ready   = req_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.mem_addr    = cur_addr_q;
  assign bus.mem_write   = mem_write_q;

  // Every output is a register updated together with the state, so each one
  // is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      wdat_q        <= '0;
      rsp_rdata_q   <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      mem_write_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_last_q    <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr_q  <= bus.req_addr;
            remaining_q <= bus.req_len;
            req_ready_q <= 1'b0;
            if (bus.req_write) begin
              wdata_ready_q <= 1'b1;
              state_q       <= WR_WAIT;
            end else begin
              state_q <= RD;
            end
          end
        end

        RD: begin
          // RAM drives the bus combinationally from mem_addr while the strobe is low.
          rsp_rdata_q <= mem_data;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= (remaining_q == '0);
          state_q     <= RD_HOLD;
        end

        RD_HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              cur_addr_q  <= cur_addr_q + ADDR_ONE;
              remaining_q <= remaining_q - ADDR_ONE;
              state_q     <= RD;
            end
          end
        end

        WR_WAIT: begin
          if (bus.wdata_valid) begin
            wdat_q        <= bus.wdata;
            wdata_ready_q <= 1'b0;
            mem_write_q   <= 1'b1;
            state_q       <= WR;
          end
        end

        WR: begin
          // RAM commits on this edge; drop the strobe and bus together.
          mem_write_q <= 1'b0;
          if (remaining_q == '0) begin
            wr_done_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cur_addr_q    <= cur_addr_q + ADDR_ONE;
            remaining_q   <= remaining_q - ADDR_ONE;
            wdata_ready_q <= 1'b1;
            state_q       <= WR_WAIT;
          end
        end

        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          req_ready_q   <= 1'b1;
          wdata_ready_q <= 1'b0;
          mem_write_q   <= 1'b0;
          rsp_valid_q   <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;
  localparam int AW = 4;
  localparam int DW = 6;
  localparam int N  = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_bus_master_if #(.address_width(AW), .data_width(DW)) bus ();
  wire [DW-1:0] mem_data;

  mem_bus_master #(.address_width(AW), .data_width(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .mem_data(mem_data)
  );

  // RAM environment: drives the bus whenever the strobe is low, writes on the edge when high.
  logic [DW-1:0] ram [N];
  assign mem_data = bus.mem_write ? {DW{1'bz}} : ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write === 1'b1) ram[bus.mem_addr] <= mem_data;

  // Reference model: what the RAM must contain according to the completed write beats.
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] wbuf [N];
  logic [AW+DW-1:0] wr_log [$];

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus ownership: defined data while strobing, otherwise only the RAM's word is on the bus.
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      chk("bus_no_x", 32'($isunknown(mem_data)), 32'd0);
      wr_log.push_back({bus.mem_addr, mem_data});
    end else begin
      chk("bus_released", 32'(mem_data), 32'(ram[bus.mem_addr]));
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input int len, input int gap);
    logic [AW-1:0] ea;
    chk("wr_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = AW'(len);
    tick();
    // keep a junk request asserted: it must be ignored outside IDLE
    bus.req_write = 1'b0;
    bus.req_addr  = AW'($urandom);
    bus.req_len   = AW'($urandom);
    wr_log.delete();
    for (int i = 0; i <= len; i++) begin
      ea = AW'(32'(a) + i);
      for (int g = 0; g < gap; g++) begin
        chk("wr_wait_wdata_ready", 32'(bus.wdata_ready), 32'd1);
        chk("wr_wait_req_ready", 32'(bus.req_ready), 32'd0);
        chk("wr_wait_strobe", 32'(bus.mem_write), 32'd0);
        bus.wdata = DW'($urandom);
        tick();
      end
      chk("wr_wdata_ready", 32'(bus.wdata_ready), 32'd1);
      bus.wdata_valid = 1'b1;
      bus.wdata       = wbuf[i];
      if (i == len) bus.req_valid = 1'b0;
      tick();
      bus.wdata_valid = 1'b0;
      bus.wdata       = DW'($urandom);
      chk("wr_strobe", 32'(bus.mem_write), 32'd1);
      chk("wr_addr", 32'(bus.mem_addr), 32'(ea));
      chk("wr_bus_data", 32'(mem_data), 32'(wbuf[i]));
      chk("wr_wdata_ready_low", 32'(bus.wdata_ready), 32'd0);
      ref_mem[ea] = wbuf[i];
      tick();
      chk("wr_strobe_drop", 32'(bus.mem_write), 32'd0);
      chk("wr_done", 32'(bus.wr_done), 32'(i == len));
    end
    tick();
    chk("wr_done_pulse_end", 32'(bus.wr_done), 32'd0);
    chk("wr_back_idle", 32'(bus.req_ready), 32'd1);
    chk("wr_beat_count", 32'(wr_log.size()), 32'(len + 1));
    for (int i = 0; i < wr_log.size() && i <= len; i++)
      chk("wr_commit", 32'(wr_log[i]), 32'({AW'(32'(a) + i), wbuf[i]}));
  endtask

  // mode 0: rsp_ready always high; 1: random; 2: stall beat 1 for 5 cycles.
  task automatic do_read(input logic [AW-1:0] a, input int len, input int mode);
    int got;
    int cyc;
    int stall;
    logic [AW-1:0] ea;
    got = 0; cyc = 0; stall = 0;
    chk("rd_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = AW'(len);
    tick();
    bus.req_addr  = AW'($urandom);
    bus.req_write = 1'($urandom);
    chk("rd_first_not_valid", 32'(bus.rsp_valid), 32'd0);
    while (got <= len && cyc < 200) begin
      ea = AW'(32'(a) + got);
      if (mode == 0) bus.rsp_ready = 1'b1;
      else if (mode == 1) bus.rsp_ready = 1'($urandom);
      else if (got == 1 && stall < 5 && bus.rsp_valid) begin
        bus.rsp_ready = 1'b0;
        stall++;
      end else bus.rsp_ready = 1'b1;
      bus.req_valid = (got < len) ? 1'($urandom) : 1'b0;
      chk("rd_req_ready_busy", 32'(bus.req_ready), 32'd0);
      chk("rd_strobe_low", 32'(bus.mem_write), 32'd0);
      chk("rd_addr", 32'(bus.mem_addr), 32'(ea));
      if (bus.rsp_valid) begin
        chk("rd_data", 32'(bus.rsp_rdata), 32'(ref_mem[ea]));
        chk("rd_last", 32'(bus.rsp_last), 32'(got == len));
        if (bus.rsp_ready) got++;
      end
      tick();
      cyc++;
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rd_beats_received", 32'(got), 32'(len + 1));
    if (mode == 0) chk("rd_rate", 32'(cyc), 32'(2 * (len + 1)));
    if (mode == 2) chk("rd_stall_cycles", 32'(cyc), 32'(2 * (len + 1) + 5));
    chk("rd_valid_after", 32'(bus.rsp_valid), 32'd0);
    chk("rd_back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < N; i++) chk(tag, 32'(ram[i]), 32'(ref_mem[i]));
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_wr_done", 32'(bus.wr_done), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_bus_released", 32'(mem_data), 32'(ram[0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    int len;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end

    // reset
    #1 reset_n = 1'b0;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // single write then read
    wbuf[0] = 6'b101101;
    do_write(4'd3, 0, 0);
    do_read(4'd3, 0, 0);

    // burst across the wrap point
    wbuf[0] = 6'd1; wbuf[1] = 6'd2; wbuf[2] = 6'd3; wbuf[3] = 6'd4;
    do_write(4'd14, 3, 0);
    do_read(4'd14, 3, 0);

    // backpressure on beat 2 of a 3-beat read
    do_read(4'd14, 2, 2);

    // write data starvation
    wbuf[0] = DW'($urandom); wbuf[1] = DW'($urandom);
    do_write(4'd7, 1, 4);

    // whole RAM, ending at start-1
    a = AW'($urandom);
    for (int i = 0; i < N; i++) wbuf[i] = DW'($urandom);
    do_write(a, N - 1, 0);
    do_read(a, N - 1, 0);
    check_ram("ram_after_full");

    // randomized bursts
    for (int t = 0; t < 10; t++) begin
      a   = AW'($urandom);
      len = int'($urandom_range(0, N - 1));
      for (int i = 0; i < N; i++) wbuf[i] = DW'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, len, int'($urandom_range(0, 2)));
      else do_read(a, len, (len == 0) ? 1 : int'($urandom_range(0, 2)));
    end
    check_ram("ram_after_random");

    // reset during WR_WAIT of beat 2 of a 3-beat write
    a = AW'($urandom);
    wbuf[0] = DW'($urandom); wbuf[1] = ~ref_mem[AW'(a + 4'd1)];
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = 4'd2;
    tick();
    bus.req_valid = 1'b0;
    bus.wdata_valid = 1'b1; bus.wdata = wbuf[0];
    tick();
    bus.wdata_valid = 1'b0;
    ref_mem[a] = wbuf[0];
    tick();
    chk("mid_wr_wait", 32'(bus.wdata_ready), 32'd1);
    bus.wdata_valid = 1'b1; bus.wdata = wbuf[1];
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    tick();
    chk("rst_held_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    chk("rst_held_mem_write", 32'(bus.mem_write), 32'd0);
    bus.wdata_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_wr_done", 32'(bus.wr_done), 32'd0);
    check_ram("ram_after_reset");
    do_read(a, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
